ball_physics_controller: RTL and testbench

// Parametrised fixed-point ball motion engine for the pinball playfield; successor to the single-ball smiley mover.

---
 rtl/ball_pkg.sv | 26 ++
 rtl/ball_axis.sv | 99 +++++++++
 rtl/ball_physics_controller.sv | 110 +++++++++++
 tb/tb_ball_physics_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared types and arithmetic helpers for the ball motion engine.
package ball_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    DRAIN  = 2'd2
  } ball_state_t;

  // Clamp a wide signed speed into [-max_speed, max_speed].
  function automatic logic signed [31:0] sat_speed(input logic signed [31:0] v,
                                                   input int max_speed);
    if (v > max_speed) return max_speed;
    if (v < -max_speed) return -max_speed;
    return v;
  endfunction

  // Damped reflection: lose v>>>damp_shift, then reverse. A zero shift is lossless
  // (the generic formula would collapse to zero there).
  function automatic logic signed [31:0] refl(input logic signed [31:0] v,
                                              input int damp_shift);
    if (damp_shift == 0) return -v;
    return -(v - (v >>> damp_shift));
  endfunction

endpackage

// File: rtl/ball_axis.sv
// One motion axis: pending collision flags, reflect/impulse select, gravity,
// speed saturation and position integration in fixed point.
module ball_axis
  import ball_pkg::*;
#(
  parameter int COORD_W      = 11,
  parameter int FRAC_BITS    = 6,
  parameter int SPEED_W      = 16,
  parameter int INIT_POS     = 280,
  parameter int LAUNCH_V     = 0,
  parameter int GRAV         = 0,
  parameter int MAX_SPEED    = 512,
  parameter int DAMP_SHIFT   = 3,
  parameter int FLIP_REFLECT = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           init,
  input  logic                           launch_load,
  input  logic                           latch,
  input  logic                           update,
  input  logic                           hit_neg,
  input  logic                           hit_pos,
  input  logic                           hit_flip,
  input  logic                           flip_gate,
  input  logic [SPEED_W-1:0]             impulse,
  output logic [COORD_W+FRAC_BITS:0]     pos,
  output logic [SPEED_W-1:0]             speed
);

  localparam int PW = COORD_W + FRAC_BITS + 1;
  localparam logic signed [PW-1:0] POS_INIT = PW'(INIT_POS * (2 ** FRAC_BITS));
  localparam logic signed [SPEED_W-1:0] LAUNCH_SPEED = SPEED_W'(LAUNCH_V);
  localparam int POS_MAX = (2 ** (PW - 1)) - 1;
  localparam int POS_MIN = -(2 ** (PW - 1));

  logic signed [PW-1:0]      pos_reg;
  logic signed [SPEED_W-1:0] speed_reg;
  logic                      pend_neg_reg, pend_pos_reg, pend_flip_reg;

  logic                      eff_neg, eff_pos, eff_flip;
  logic signed [31:0]        v_cur, v_sel, v_int, v_store, pos_sum;

  assign pos   = pos_reg;
  assign speed = speed_reg;

  // Frame math: pulses arriving on the update cycle count as pending; the
  // position integrates the post-reflection speed, gravity only affects storage.
  always_comb begin
    eff_neg  = pend_neg_reg | hit_neg;
    eff_pos  = pend_pos_reg | hit_pos;
    eff_flip = pend_flip_reg | hit_flip;
    v_cur    = 32'(speed_reg);
    v_sel    = v_cur;
    if (eff_neg && (v_cur < 0))
      v_sel = refl(v_cur, DAMP_SHIFT);
    else if (eff_pos && (v_cur > 0))
      v_sel = refl(v_cur, DAMP_SHIFT);
    else if (eff_flip && flip_gate)
      v_sel = (FLIP_REFLECT != 0) ? refl(v_cur, DAMP_SHIFT) : v_cur + 32'($signed(impulse));
    v_int   = sat_speed(v_sel, MAX_SPEED);
    v_store = sat_speed(v_sel + GRAV, MAX_SPEED);
    pos_sum = 32'(pos_reg) + v_int;
  end

  // Axis state: reset/init park the ball, launch loads speed, update integrates,
  // otherwise collision pulses accumulate while in flight.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      pos_reg       <= POS_INIT;
      speed_reg     <= '0;
      pend_neg_reg  <= 1'b0;
      pend_pos_reg  <= 1'b0;
      pend_flip_reg <= 1'b0;
    end else if (launch_load) begin
      speed_reg     <= LAUNCH_SPEED;
      pend_neg_reg  <= 1'b0;
      pend_pos_reg  <= 1'b0;
      pend_flip_reg <= 1'b0;
    end else if (update) begin
      pos_reg       <= PW'(pos_sum);
      speed_reg     <= SPEED_W'(v_store);
      pend_neg_reg  <= 1'b0;
      pend_pos_reg  <= 1'b0;
      pend_flip_reg <= 1'b0;
    end else if (latch) begin
      pend_neg_reg  <= pend_neg_reg | hit_neg;
      pend_pos_reg  <= pend_pos_reg | hit_pos;
      pend_flip_reg <= pend_flip_reg | hit_flip;
    end
  end

  // Position must never wrap; the drain line and speed clamp should prevent it.
  always_ff @(posedge clk) begin
    if (!reset && !init && !launch_load && update)
      assert ((pos_sum <= POS_MAX) && (pos_sum >= POS_MIN));
  end

endmodule

// File: rtl/ball_physics_controller.sv
// Ball motion engine top: launch/flight/drain FSM, drain compare and
// integer pixel conversion around one ball_axis per coordinate.
module ball_physics_controller
  import ball_pkg::*;
#(
  parameter int COORD_W    = 11,
  parameter int FRAC_BITS  = 6,
  parameter int SPEED_W    = 16,
  parameter int INITIAL_X  = 280,
  parameter int INITIAL_Y  = 185,
  parameter int LAUNCH_VY  = -100,
  parameter int GRAVITY    = 1,
  parameter int MAX_SPEED  = 512,
  parameter int DAMP_SHIFT = 3,
  parameter int DRAIN_Y    = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               pause,
  input  logic               launch,
  input  logic               collTop,
  input  logic               collLeft,
  input  logic               collRight,
  input  logic               collFlipper,
  input  logic [SPEED_W-1:0] flipperSpeedX,
  output logic [COORD_W-1:0] topLeftX,
  output logic [COORD_W-1:0] topLeftY,
  output logic               ballActive,
  output logic               drained
);

  localparam int PW = COORD_W + FRAC_BITS + 1;
  localparam logic signed [COORD_W-1:0] DRAIN_Y_C = COORD_W'(DRAIN_Y);

  ball_state_t         state_reg;
  logic [PW-1:0]       pos_x, pos_y;
  logic [SPEED_W-1:0]  x_speed, y_speed;
  logic                in_flight, launch_go, drain_hit, frame_go, axis_init, ys_positive;

  assign topLeftX    = COORD_W'($signed(pos_x) >>> FRAC_BITS);
  assign topLeftY    = COORD_W'($signed(pos_y) >>> FRAC_BITS);
  assign in_flight   = (state_reg == FLIGHT);
  assign launch_go   = (state_reg == IDLE) && launch && !pause;
  assign drain_hit   = in_flight && ($signed(topLeftY) >= DRAIN_Y_C);
  assign frame_go    = in_flight && !drain_hit && startOfFrame && !pause;
  assign axis_init   = !in_flight && !launch_go;
  assign ys_positive = ($signed(y_speed) > 0);

  ball_axis #(
    .COORD_W(COORD_W), .FRAC_BITS(FRAC_BITS), .SPEED_W(SPEED_W),
    .INIT_POS(INITIAL_X), .LAUNCH_V(0), .GRAV(0),
    .MAX_SPEED(MAX_SPEED), .DAMP_SHIFT(DAMP_SHIFT), .FLIP_REFLECT(0)
  ) u_axis_x (
    .clk(clk), .reset(reset), .init(axis_init), .launch_load(launch_go),
    .latch(in_flight), .update(frame_go),
    .hit_neg(collLeft), .hit_pos(collRight), .hit_flip(collFlipper),
    .flip_gate(ys_positive), .impulse(flipperSpeedX),
    .pos(pos_x), .speed(x_speed)
  );

  ball_axis #(
    .COORD_W(COORD_W), .FRAC_BITS(FRAC_BITS), .SPEED_W(SPEED_W),
    .INIT_POS(INITIAL_Y), .LAUNCH_V(LAUNCH_VY), .GRAV(GRAVITY),
    .MAX_SPEED(MAX_SPEED), .DAMP_SHIFT(DAMP_SHIFT), .FLIP_REFLECT(1)
  ) u_axis_y (
    .clk(clk), .reset(reset), .init(axis_init), .launch_load(launch_go),
    .latch(in_flight), .update(frame_go),
    .hit_neg(collTop), .hit_pos(1'b0), .hit_flip(collFlipper),
    .flip_gate(ys_positive), .impulse('0),
    .pos(pos_y), .speed(y_speed)
  );

  // Ball lifecycle with registered status outputs; drained is high for the
  // single DRAIN cycle and the axes re-park on the following IDLE entry edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      ballActive <= 1'b0;
      drained    <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          drained <= 1'b0;
          if (launch_go) begin
            state_reg  <= FLIGHT;
            ballActive <= 1'b1;
          end
        end
        FLIGHT: begin
          if (drain_hit) begin
            state_reg  <= DRAIN;
            ballActive <= 1'b0;
            drained    <= 1'b1;
          end
        end
        DRAIN: begin
          state_reg <= IDLE;
          drained   <= 1'b0;
        end
        default: begin
          state_reg  <= IDLE;
          ballActive <= 1'b0;
          drained    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_physics_controller.sv
// Bench for ball_physics_controller: directed scenarios plus randomized play
// against an integer-arithmetic model of the ball rules.
module tb_ball_physics_controller;

  localparam int FRAC      = 6;
  localparam int INIT_X    = 280;
  localparam int INIT_Y    = 185;
  localparam int LAUNCH_VY = -100;
  localparam int GRAV      = 1;
  localparam int MAXS      = 512;
  localparam int DAMP      = 3;
  localparam int DRAIN_Y   = 480;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, pause, launch;
  logic        collTop, collLeft, collRight, collFlipper;
  logic [15:0] flipperSpeedX;
  logic [10:0] topLeftX, topLeftY;
  logic        ballActive, drained;

  int n_vec  = 0;
  int n_miss = 0;

  // model: 0 idle, 1 flight, 2 drain
  int m_state, m_px, m_py, m_vx, m_vy;
  bit m_pl, m_pr, m_pt, m_pf, m_active, m_drained;

  always #5 clk = ~clk;

  ball_physics_controller dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .pause(pause),
    .launch(launch), .collTop(collTop), .collLeft(collLeft),
    .collRight(collRight), .collFlipper(collFlipper),
    .flipperSpeedX(flipperSpeedX), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .ballActive(ballActive), .drained(drained)
  );

  function automatic int floor_div(int a, int b);
    int q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int clamp(int v);
    return (v > MAXS) ? MAXS : ((v < -MAXS) ? -MAXS : v);
  endfunction

  function automatic int refl_m(int v);
    if (DAMP == 0) return -v;
    return -(v - floor_div(v, 2 ** DAMP));
  endfunction

  // integer pixel, wrapped to an 11-bit signed output
  function automatic int px_of(int p);
    int q = floor_div(p, 2 ** FRAC);
    return ((q + 1024) % 2048 + 2048) % 2048 - 1024;
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_park();
    m_px = INIT_X * (2 ** FRAC);
    m_py = INIT_Y * (2 ** FRAC);
    m_vx = 0; m_vy = 0;
    m_pl = 0; m_pr = 0; m_pt = 0; m_pf = 0;
  endtask

  task automatic model_step();
    bit l, r, t, f;
    int nvx, nvy;
    if (reset) begin
      model_park();
      m_state = 0; m_active = 0; m_drained = 0;
      return;
    end
    case (m_state)
      0: begin
        m_drained = 0;
        model_park();
        if (launch && !pause) begin
          m_state = 1; m_active = 1; m_vy = LAUNCH_VY; m_vx = 0;
        end
      end
      1: begin
        if (px_of(m_py) >= DRAIN_Y) begin
          m_state = 2; m_active = 0; m_drained = 1;
        end else begin
          l = m_pl | collLeft; r = m_pr | collRight;
          t = m_pt | collTop;  f = m_pf | collFlipper;
          if (startOfFrame && !pause) begin
            nvx = m_vx;
            if (l && m_vx < 0) nvx = refl_m(m_vx);
            else if (r && m_vx > 0) nvx = refl_m(m_vx);
            else if (f && m_vy > 0) nvx = m_vx + int'($signed(flipperSpeedX));
            nvy = m_vy;
            if (t && m_vy < 0) nvy = refl_m(m_vy);
            else if (f && m_vy > 0) nvy = refl_m(m_vy);
            m_px = m_px + clamp(nvx);
            m_py = m_py + clamp(nvy);
            m_vx = clamp(nvx);
            m_vy = clamp(nvy + GRAV);
            m_pl = 0; m_pr = 0; m_pt = 0; m_pf = 0;
          end else begin
            m_pl = l; m_pr = r; m_pt = t; m_pf = f;
          end
        end
      end
      default: begin
        m_state = 0; m_drained = 0;
        model_park();
      end
    endcase
  endtask

  task automatic check_all();
    check_val("topLeftX", int'($signed(topLeftX)), px_of(m_px));
    check_val("topLeftY", int'($signed(topLeftY)), px_of(m_py));
    check_val("ballActive", int'(ballActive), int'(m_active));
    check_val("drained", int'(drained), int'(m_drained));
    check_val("x_speed", int'($signed(dut.x_speed)), m_vx);
    check_val("y_speed", int'($signed(dut.y_speed)), m_vy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic clear_inputs();
    startOfFrame = 0; pause = 0; launch = 0;
    collTop = 0; collLeft = 0; collRight = 0; collFlipper = 0;
    flipperSpeedX = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_launch();
    launch = 1'b1;
    tick();
    launch = 1'b0;
  endtask

  task automatic flipper_frame(input int impulse);
    collFlipper   = 1'b1;
    flipperSpeedX = 16'(impulse);
    frame();
    collFlipper   = 1'b0;
  endtask

  initial begin
    bit seen;
    int xp, yp, imp;
    clear_inputs();
    reset = 1'b1;
    model_park();
    m_state = 0; m_active = 0; m_drained = 0;
    @(negedge clk);
    tick();
    reset = 1'b0;

    // reset in mid-flight parks the ball
    do_launch();
    frames(4);
    do_reset();
    check_val("rst_x", int'($signed(topLeftX)), 280);
    check_val("rst_y", int'($signed(topLeftY)), 185);
    check_val("rst_active", int'(ballActive), 0);
    check_val("rst_vy", int'($signed(dut.y_speed)), 0);

    // launch and three free frames
    do_launch();
    check_val("launch_active", int'(ballActive), 1);
    check_val("launch_vy", int'($signed(dut.y_speed)), -100);
    frame();
    check_val("f1_y", int'($signed(topLeftY)), 183);
    check_val("f1_vy", int'($signed(dut.y_speed)), -99);
    frame();
    check_val("f2_y", int'($signed(topLeftY)), 181);
    frame();
    check_val("f3_y", int'($signed(topLeftY)), 180);
    check_val("f3_vy", int'($signed(dut.y_speed)), -97);

    // flipper while falling gives Xs=-64, then a latched left hit reflects it
    frames(98);
    check_val("t3_vy", int'($signed(dut.y_speed)), 1);
    flipper_frame(-64);
    check_val("t3_vx", int'($signed(dut.x_speed)), -64);
    check_val("t3_x", int'($signed(topLeftX)), 279);
    collLeft = 1'b1;
    tick();
    collLeft = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    frame();
    check_val("left_vx", int'($signed(dut.x_speed)), 56);
    check_val("left_x", int'($signed(topLeftX)), 279);

    // flipper reflection at Ys=+200
    do_reset();
    do_launch();
    frames(300);
    check_val("t4_vy_pre", int'($signed(dut.y_speed)), 200);
    flipper_frame(40);
    check_val("t4_vy", int'($signed(dut.y_speed)), -174);
    check_val("t4_vx", int'($signed(dut.x_speed)), 40);

    // impulse saturation then a long pause
    frames(175);
    check_val("t5_vy_pre", int'($signed(dut.y_speed)), 1);
    flipper_frame(1000);
    check_val("t5_vx_sat", int'($signed(dut.x_speed)), 512);
    xp = px_of(m_px);
    yp = px_of(m_py);
    pause = 1'b1;
    collTop = 1'b1;
    frames(10);
    collTop = 1'b0;
    check_val("pause_x", int'($signed(topLeftX)), xp);
    check_val("pause_y", int'($signed(topLeftY)), yp);
    pause = 1'b0;

    // free fall to the drain line
    do_reset();
    do_launch();
    seen = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      startOfFrame = (c % 2 == 0);
      tick();
      if (drained) seen = 1;
    end
    startOfFrame = 1'b0;
    check_val("drain_seen", int'(seen), 1);
    launch = 1'b1;
    tick();
    launch = 1'b0;
    check_val("drain_pulse_end", int'(drained), 0);
    check_val("drain_active", int'(ballActive), 0);
    check_val("drain_x", int'($signed(topLeftX)), 280);
    check_val("drain_y", int'($signed(topLeftY)), 185);
    tick();
    check_val("drain_launch_ign", int'(ballActive), 0);

    // randomized play with walls driven from the model's position
    for (int c = 0; c < 12000; c++) begin
      xp = floor_div(m_px, 64);
      yp = floor_div(m_py, 64);
      imp = int'($urandom_range(40)) - 20;
      reset        = ($urandom_range(2999) == 0);
      launch       = (m_state == 0) ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0);
      startOfFrame = ($urandom_range(1) == 0);
      pause        = ($urandom_range(15) == 0);
      collLeft     = (xp < 20)  || ($urandom_range(63) == 0);
      collRight    = (xp > 600) || ($urandom_range(63) == 0);
      collTop      = (yp < 10)  || ($urandom_range(63) == 0);
      collFlipper  = ((yp > 380) && ($urandom_range(7) == 0)) || ($urandom_range(127) == 0);
      flipperSpeedX = 16'(imp);
      tick();
    end
    clear_inputs();
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
